// File: rtl/alu_pkg.sv
// Shared instruction definitions for the ALU execution units.
// Holds opcodes, the sequential unit's FSM states and the default-width instruction word.
package alu_pkg;

  localparam logic [23:0] VERSION = "2.0";

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2
  } opcodes_t;

  // 2'd3 is reserved; decoders must flag it rather than alias it onto a real op
  localparam logic [1:0] OP_RESERVED = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    DONE
  } state_t;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [1:0]      opcode;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } instr_t;

  function automatic logic op_is_legal(input logic [1:0] op);
    return op != OP_RESERVED;
  endfunction

endpackage

// File: rtl/alu_seq_unit_mul.sv
// Iterative unsigned shift-add multiplier, MUL_UNROLL multiplier bits retired per cycle.
// done is high in the last busy cycle; product is final from the following edge on.
module seq_multiplier #(
  parameter int WIDTH      = 32,
  parameter int MUL_UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int STEPS = WIDTH / MUL_UNROLL;
  localparam int CW    = $clog2(STEPS + 1);

  if (WIDTH < 4 || !(MUL_UNROLL == 1 || MUL_UNROLL == 2 || MUL_UNROLL == 4) ||
      (WIDTH % MUL_UNROLL) != 0) begin : g_bad_param
    $error("seq_multiplier: unsupported WIDTH/MUL_UNROLL combination");
  end

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_pp;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  always_comb begin
    w_pp = '0;
    for (int k = 0; k < MUL_UNROLL; k++) begin
      if (r_mplier[k]) w_pp = w_pp + (r_mcand << k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (clear) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (r_busy) begin
      r_acc    <= r_acc + w_pp;
      r_mcand  <= r_mcand << MUL_UNROLL;
      r_mplier <= r_mplier >> MUL_UNROLL;
      r_cnt    <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= CW'(STEPS);
      r_busy   <= 1'b1;
    end
  end

  // Early done lets the owner enter its result state on the same edge the last partial lands
  assign done    = r_busy && (r_cnt == CW'(1));
  assign product = r_acc;

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked execution unit: single-cycle ADD/SUB, iterative MUL, one instruction in flight.
// Results are presented from registered operands/product while in DONE and zero otherwise.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             out_err,
  output logic             busy
);
  typedef struct packed {
    logic [1:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } instr_w_t;

  state_t             r_state, w_next;
  instr_w_t           r_instr;
  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;

  // flush outranks a same-cycle accept even though in_ready is still shown high
  assign w_accept    = in_valid && (r_state == IDLE) && !flush;
  assign w_mul_start = w_accept && (in_opcode == MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (w_accept) w_next = (in_opcode == MUL) ? MUL_BUSY : DONE;
        MUL_BUSY: if (w_mul_done) w_next = DONE;
        DONE:     if (out_ready) w_next = IDLE;
        default:  w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instr <= '0;
    else if (w_accept) r_instr <= '{opcode: in_opcode, a: in_a, b: in_b};
  end

  seq_multiplier #(
    .WIDTH      (WIDTH),
    .MUL_UNROLL (MUL_UNROLL)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .start   (w_mul_start),
    .a       (in_a),
    .b       (in_b),
    .done    (w_mul_done),
    .product (w_product)
  );

  assign w_sum  = {1'b0, r_instr.a} + {1'b0, r_instr.b};
  assign w_diff = {1'b0, r_instr.a} - {1'b0, r_instr.b};

  always_comb begin
    out_valid  = 1'b0;
    out_result = '0;
    out_ovf    = 1'b0;
    out_err    = 1'b0;
    if (r_state == DONE) begin
      out_valid = 1'b1;
      if (!op_is_legal(r_instr.opcode)) begin
        out_err = 1'b1;
      end else begin
        case (r_instr.opcode)
          ADD: begin
            out_result = w_sum[WIDTH-1:0];
            out_ovf    = w_sum[WIDTH];
          end
          SUB: begin
            out_result = w_diff[WIDTH-1:0];
            out_ovf    = w_diff[WIDTH];
          end
          default: begin
            out_result = w_product[WIDTH-1:0];
            out_ovf    = |w_product[2*WIDTH-1:WIDTH];
          end
        endcase
      end
    end
  end

  // in_ready is held low during reset so every output reads zero while rst_n is asserted
  assign in_ready = rst_n && (r_state == IDLE);
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: one instance at MUL_UNROLL=1, one at MUL_UNROLL=4.
module tb_alu_seq_unit;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic         in_valid = 1'b0, v4 = 1'b0, out_ready = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0, b = '0;

  logic         rdy1, val1, ovf1, err1, bsy1;
  logic [W-1:0] res1;
  logic         rdy4, val4, ovf4, err4, bsy4;
  logic [W-1:0] res4;

  int n_chk = 0, n_err = 0;
  int lat, seen;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W), .MUL_UNROLL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_opcode(op), .in_a(a), .in_b(b), .out_valid(val1), .out_ready(out_ready),
    .out_result(res1), .out_ovf(ovf1), .out_err(err1), .busy(bsy1));

  alu_seq_unit #(.WIDTH(W), .MUL_UNROLL(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v4), .in_ready(rdy4),
    .in_opcode(op), .in_a(a), .in_b(b), .out_valid(val4), .out_ready(out_ready),
    .out_result(res4), .out_ovf(ovf4), .out_err(err4), .busy(bsy4));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic to4);
    op = o; a = x; b = y;
    if (to4) v4 = 1'b1; else in_valid = 1'b1;
    step;
    in_valid = 1'b0; v4 = 1'b0;
  endtask

  // latency counts the cycle right after the accept edge as 1
  task automatic wait1(output int l);
    l = 1;
    while (!val1 && l < 200) begin step; l++; end
  endtask

  task automatic wait4(output int l);
    l = 1;
    while (!val4 && l < 200) begin step; l++; end
  endtask

  task automatic hs;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask

  initial begin
    step; step;
    chk("rst_valid", val1, 0);
    chk("rst_ready", rdy1, 0);
    chk("rst_busy", bsy1, 0);
    chk("rst_result", res1, 0);
    rst_n = 1'b1;
    step;
    chk("idle_ready", rdy1, 1);
    chk("idle_valid", val1, 0);
    chk("idle_busy", bsy1, 0);

    issue(2'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    chk("add_valid", val1, 1);
    chk("add_result", res1, 0);
    chk("add_ovf", ovf1, 1);
    chk("add_err", err1, 0);
    chk("add_ready", rdy1, 0);
    step;
    chk("add_hold_ready", rdy1, 0);
    chk("add_hold_valid", val1, 1);
    hs;
    chk("add_hs_valid", val1, 0);
    chk("add_hs_ready", rdy1, 1);

    issue(2'd1, 32'd5, 32'd7, 1'b0);
    chk("sub_result", res1, 32'hFFFF_FFFE);
    chk("sub_ovf", ovf1, 1);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("sub_stall_valid", val1, 1);
      chk("sub_stall_result", res1, 32'hFFFF_FFFE);
      chk("sub_stall_ovf", ovf1, 1);
      chk("sub_stall_ready", rdy1, 0);
    end
    hs;

    issue(2'd2, 32'h0001_0000, 32'h0001_0000, 1'b0);
    wait1(lat);
    chk("mul1_lat", lat, 33);
    chk("mul1_result", res1, 0);
    chk("mul1_ovf", ovf1, 1);
    hs;

    issue(2'd2, 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait4(lat);
    chk("mul4_lat", lat, 9);
    chk("mul4_result", res4, 0);
    chk("mul4_ovf", ovf4, 1);
    hs;

    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait4(lat);
    chk("mul4_max_result", res4, 1);
    chk("mul4_max_ovf", ovf4, 1);
    hs;

    issue(2'd2, 32'h0, 32'hDEAD_BEEF, 1'b1);
    wait4(lat);
    chk("mul4_zero_result", res4, 0);
    chk("mul4_zero_ovf", ovf4, 0);
    chk("mul4_zero_err", err4, 0);
    hs;

    issue(2'd2, 32'd1234, 32'd5678, 1'b0);
    wait1(lat);
    chk("mul_small_lat", lat, 33);
    chk("mul_small_result", res1, 32'd7006652);
    chk("mul_small_ovf", ovf1, 0);
    hs;

    issue(2'd2, 32'd1234, 32'd5678, 1'b0);
    repeat (9) step;
    chk("mul_flush_busy_before", bsy1, 1);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("mul_flush_busy", bsy1, 0);
    chk("mul_flush_ready", rdy1, 1);
    chk("mul_flush_valid", val1, 0);
    seen = 0;
    repeat (40) begin
      step;
      if (val1) seen = 1;
    end
    chk("mul_flush_no_valid", seen, 0);
    issue(2'd0, 32'd2, 32'd3, 1'b0);
    chk("add_after_flush_valid", val1, 1);
    chk("add_after_flush_result", res1, 5);
    chk("add_after_flush_ovf", ovf1, 0);
    hs;

    issue(2'd3, 32'd9, 32'd9, 1'b0);
    chk("ill_valid", val1, 1);
    chk("ill_result", res1, 0);
    chk("ill_err", err1, 1);
    chk("ill_ovf", ovf1, 0);
    hs;

    issue(2'd3, 32'd9, 32'd9, 1'b0);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("flush_done_valid", val1, 0);
    chk("flush_done_err", err1, 0);
    chk("flush_done_ready", rdy1, 1);

    op = 2'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    step;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_wins_busy", bsy1, 0);
    chk("flush_wins_valid", val1, 0);
    step;
    chk("flush_wins_valid_later", val1, 0);

    issue(2'd2, 32'd1234, 32'd5678, 1'b0);
    repeat (5) step;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", val1, 0);
    chk("rst_mid_busy", bsy1, 0);
    chk("rst_mid_ready", rdy1, 0);
    chk("rst_mid_result", res1, 0);
    step;
    #2 rst_n = 1'b1;
    step;
    chk("rst_rel_ready", rdy1, 1);
    chk("rst_rel_busy", bsy1, 0);
    issue(2'd2, 32'd3, 32'd4, 1'b0);
    wait1(lat);
    chk("mul_3x4_lat", lat, 33);
    chk("mul_3x4_result", res1, 12);
    chk("mul_3x4_ovf", ovf1, 0);
    hs;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
